// File: rtl/core_pkg.sv
// Shared types, constants and the rotation index map for the tile buffer.
package core_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'h0,
    ST_FILL  = 2'h1,
    ST_DRAIN = 2'h2
  } state_e;

  localparam logic [1:0] DEG_0   = 2'h0;
  localparam logic [1:0] DEG_90  = 2'h1;
  localparam logic [1:0] DEG_180 = 2'h2;
  localparam logic [1:0] DEG_270 = 2'h3;

  localparam int TILE_PIX = 64;

  // Counter-clockwise turns are folded into the equivalent clockwise amount.
  function automatic logic [1:0] eff_degrees(input logic dir, input logic [1:0] deg);
    return dir ? deg : (2'd0 - deg);
  endfunction

  // Source (row*8+col) of output index k for a clockwise rotation of eff.
  function automatic logic [5:0] rot_index(input logic [1:0] eff, input logic [5:0] k);
    logic [2:0] i;
    logic [2:0] j;
    logic [5:0] src;
    i = k[5:3];
    j = k[2:0];
    case (eff)
      DEG_0:   src = {i, j};
      DEG_90:  src = {3'd7 - j, i};
      DEG_180: src = {3'd7 - i, 3'd7 - j};
      DEG_270: src = {j, 3'd7 - i};
      default: src = {i, j};
    endcase
    return src;
  endfunction

endpackage

// File: rtl/core_tile_buf_if.sv
// Pixel-stream and control bundle between the rotate engine and the tile buffer.
interface core_tile_buf_if #(
  parameter int PIX_W = 24
);

  logic             I_START;
  logic             I_DIRECTION;
  logic [1:0]       I_DEGREES;
  logic             I_LAST_TILE;
  logic             I_ABORT;
  logic             I_WR_VALID;
  logic [PIX_W-1:0] I_WR_DATA;
  logic             O_WR_READY;
  logic             O_RD_VALID;
  logic [PIX_W-1:0] O_RD_DATA;
  logic             I_RD_READY;
  logic [6:0]       O_COUNT;
  logic             O_BUSY;

  modport slave (
    input  I_START, I_DIRECTION, I_DEGREES, I_LAST_TILE, I_ABORT,
    input  I_WR_VALID, I_WR_DATA, I_RD_READY,
    output O_WR_READY, O_RD_VALID, O_RD_DATA, O_COUNT, O_BUSY
  );

  modport master (
    output I_START, I_DIRECTION, I_DEGREES, I_LAST_TILE, I_ABORT,
    output I_WR_VALID, I_WR_DATA, I_RD_READY,
    input  O_WR_READY, O_RD_VALID, O_RD_DATA, O_COUNT, O_BUSY
  );

endinterface

// File: rtl/core_tile_ram.sv
// Tile storage: flop array, one synchronous write port, one combinational read port.
module core_tile_ram #(
  parameter int PIX_W = 24,
  parameter int DEPTH = 64
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [PIX_W-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [PIX_W-1:0]         rdata_o
);

  logic [PIX_W-1:0] mem [DEPTH];

  // Pixel contents carry no reset; every entry is rewritten before it is read.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/core_tile_buf.sv
// Tile buffer: fills one 8x8 tile row-major, then replays it in rotated order.
module core_tile_buf
  import core_pkg::*;
#(
  parameter int PIX_W    = 24,
  parameter int TILE_DIM = 8
) (
  input  logic           I_HCLK,
  input  logic           I_HRESET_N,
  core_tile_buf_if.slave bus
);

  localparam int         DEPTH    = TILE_DIM * TILE_DIM;
  localparam logic [5:0] LAST_IDX = 6'(DEPTH - 1);
  localparam logic [6:0] FULL_CNT = 7'(TILE_PIX);

  state_e           state_q, state_d;
  logic [5:0]       wrIdx_q, wrIdx_d;
  logic [6:0]       rdIdx_q, rdIdx_d;
  logic [6:0]       count_q, count_d;
  logic             rdValid_q, rdValid_d;
  logic [PIX_W-1:0] rdData_q, rdData_d;
  logic             dir_q, dir_d;
  logic [1:0]       deg_q, deg_d;
  logic             last_q, last_d;

  logic             wrAccept;
  logic             rdAccept;
  logic             rdLoad;
  logic [1:0]       eff;
  logic [5:0]       rdAddr;
  logic [PIX_W-1:0] ramRdata;

  assign eff      = eff_degrees(dir_q, deg_q);
  assign rdAddr   = rot_index(eff, rdIdx_q[5:0]);
  assign wrAccept = (state_q == ST_FILL) && bus.I_WR_VALID && !bus.I_ABORT;
  assign rdAccept = (state_q == ST_DRAIN) && rdValid_q && bus.I_RD_READY;
  assign rdLoad   = (state_q == ST_DRAIN) && (!rdValid_q || bus.I_RD_READY)
                    && (rdIdx_q < FULL_CNT);

  core_tile_ram #(
    .PIX_W (PIX_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk_i   (I_HCLK),
    .we_i    (wrAccept),
    .waddr_i (wrIdx_q),
    .wdata_i (bus.I_WR_DATA),
    .raddr_i (rdAddr),
    .rdata_o (ramRdata)
  );

  // Next-state and datapath decisions; abort overrides everything else.
  always_comb begin
    state_d   = state_q;
    wrIdx_d   = wrIdx_q;
    rdIdx_d   = rdIdx_q;
    count_d   = count_q;
    rdValid_d = rdValid_q;
    rdData_d  = rdData_q;
    dir_d     = dir_q;
    deg_d     = deg_q;
    last_d    = last_q;

    if (bus.I_ABORT) begin
      state_d   = ST_IDLE;
      wrIdx_d   = '0;
      rdIdx_d   = '0;
      count_d   = '0;
      rdValid_d = 1'b0;
      last_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.I_START) begin
            state_d = ST_FILL;
            dir_d   = bus.I_DIRECTION;
            deg_d   = bus.I_DEGREES;
            last_d  = 1'b0;
          end
        end

        ST_FILL: begin
          if (bus.I_LAST_TILE) begin
            last_d = 1'b1;
          end
          if (wrAccept) begin
            wrIdx_d = wrIdx_q + 6'd1;
            count_d = count_q + 7'd1;
            if (wrIdx_q == LAST_IDX) begin
              state_d = ST_DRAIN;
              wrIdx_d = '0;
            end
          end
        end

        ST_DRAIN: begin
          if (bus.I_LAST_TILE) begin
            last_d = 1'b1;
          end
          if (rdAccept) begin
            count_d = count_q - 7'd1;
          end
          if (rdLoad) begin
            rdData_d  = ramRdata;
            rdValid_d = 1'b1;
            rdIdx_d   = rdIdx_q + 7'd1;
          end else if (rdAccept) begin
            rdValid_d = 1'b0;
          end
          if (rdAccept && (rdIdx_q == FULL_CNT)) begin
            state_d   = (last_q || bus.I_LAST_TILE) ? ST_IDLE : ST_FILL;
            rdIdx_d   = '0;
            wrIdx_d   = '0;
            rdValid_d = 1'b0;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge I_HCLK or negedge I_HRESET_N) begin
    if (!I_HRESET_N) begin
      state_q   <= ST_IDLE;
      wrIdx_q   <= '0;
      rdIdx_q   <= '0;
      count_q   <= '0;
      rdValid_q <= 1'b0;
      rdData_q  <= '0;
      dir_q     <= 1'b0;
      deg_q     <= '0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wrIdx_q   <= wrIdx_d;
      rdIdx_q   <= rdIdx_d;
      count_q   <= count_d;
      rdValid_q <= rdValid_d;
      rdData_q  <= rdData_d;
      dir_q     <= dir_d;
      deg_q     <= deg_d;
      last_q    <= last_d;
    end
  end

  assign bus.O_WR_READY = (state_q == ST_FILL);
  assign bus.O_BUSY     = (state_q != ST_IDLE);
  assign bus.O_RD_VALID = rdValid_q;
  assign bus.O_RD_DATA  = rdData_q;
  assign bus.O_COUNT    = count_q;

endmodule

// File: tb/tb_core_tile_buf.sv
// Directed bench for the rotating tile buffer.
module tb_core_tile_buf;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  logic [23:0] got   [64];
  logic [23:0] got90 [64];
  int          gotN;

  core_tile_buf_if #(.PIX_W(24)) bus ();

  core_tile_buf #(
    .PIX_W    (24),
    .TILE_DIM (8)
  ) dut (
    .I_HCLK     (clk),
    .I_HRESET_N (rst_n),
    .bus        (bus)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so a stuck DUT still ends the run.
  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "[TB] watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic dir, input logic [1:0] deg);
    bus.I_DIRECTION = dir;
    bus.I_DEGREES   = deg;
    bus.I_START     = 1'b1;
    step();
    bus.I_START     = 1'b0;
    bus.I_DIRECTION = ~dir;
    bus.I_DEGREES   = deg + 2'd1;
    checks++;
    if (bus.O_BUSY !== 1'b1 || bus.O_WR_READY !== 1'b1 || bus.O_COUNT !== 7'd0) begin
      errors++;
      $display("FAIL start: busy=%b wr_ready=%b count=%0d, required 1 1 0",
               bus.O_BUSY, bus.O_WR_READY, bus.O_COUNT);
    end
  endtask

  task automatic fill_tile(input int base, input int lastAt, input int startAt);
    for (int k = 0; k < 64; k++) begin
      bus.I_WR_VALID  = 1'b1;
      bus.I_WR_DATA   = 24'(base + k);
      bus.I_LAST_TILE = (k == lastAt);
      bus.I_START     = (k == startAt);
      step();
      if (k == 31) begin
        checks++;
        if (bus.O_COUNT !== 7'd32) begin
          errors++;
          $display("FAIL fill_count_mid: count=%0d, required 32", bus.O_COUNT);
        end
      end
    end
    bus.I_WR_VALID  = 1'b0;
    bus.I_LAST_TILE = 1'b0;
    bus.I_START     = 1'b0;
    checks++;
    if (bus.O_COUNT !== 7'd64 || bus.O_WR_READY !== 1'b0 || bus.O_RD_VALID !== 1'b0
        || bus.O_BUSY !== 1'b1) begin
      errors++;
      $display("FAIL fill_done: count=%0d wr_ready=%b rd_valid=%b busy=%b, required 64 0 0 1",
               bus.O_COUNT, bus.O_WR_READY, bus.O_RD_VALID, bus.O_BUSY);
    end
  endtask

  task automatic drain_tile(input int pct, input logic lastLvl);
    int          cyc;
    logic        stalled;
    logic [23:0] held;
    gotN    = 0;
    cyc     = 0;
    stalled = 1'b0;
    held    = '0;
    while (gotN < 64 && cyc < 2000) begin
      if (stalled) begin
        checks++;
        if (bus.O_RD_VALID !== 1'b1 || bus.O_RD_DATA !== held) begin
          errors++;
          $display("FAIL stall_hold: valid=%b data=%0d, required 1 %0d",
                   bus.O_RD_VALID, bus.O_RD_DATA, held);
        end
      end
      bus.I_RD_READY  = ($urandom_range(99) < pct);
      bus.I_LAST_TILE = lastLvl;
      stalled = bus.O_RD_VALID && !bus.I_RD_READY;
      held    = bus.O_RD_DATA;
      if (bus.O_RD_VALID && bus.I_RD_READY) begin
        got[gotN] = bus.O_RD_DATA;
        gotN++;
      end
      step();
      cyc++;
    end
    bus.I_RD_READY  = 1'b0;
    bus.I_LAST_TILE = 1'b0;
    checks++;
    if (gotN != 64) begin
      errors++;
      $display("FAIL drain_count: received %0d pixels, required 64", gotN);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.I_START = 1'b0; bus.I_DIRECTION = 1'b0; bus.I_DEGREES = 2'd0;
    bus.I_LAST_TILE = 1'b0; bus.I_ABORT = 1'b0; bus.I_WR_VALID = 1'b0;
    bus.I_WR_DATA = '0; bus.I_RD_READY = 1'b0;
    repeat (3) step();
    checks++;
    if (bus.O_RD_VALID !== 1'b0 || bus.O_RD_DATA !== 24'd0 || bus.O_COUNT !== 7'd0
        || bus.O_BUSY !== 1'b0 || bus.O_WR_READY !== 1'b0) begin
      errors++;
      $display("FAIL reset: valid=%b data=%0d count=%0d busy=%b wr_ready=%b, required all 0",
               bus.O_RD_VALID, bus.O_RD_DATA, bus.O_COUNT, bus.O_BUSY, bus.O_WR_READY);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_identity();
    start_frame(1'b1, 2'd0);
    fill_tile(0, -1, -1);
    bus.I_RD_READY = 1'b1;
    step();
    checks++;
    if (bus.O_RD_VALID !== 1'b1 || bus.O_RD_DATA !== 24'd0) begin
      errors++;
      $display("FAIL first_valid: valid=%b data=%0d, required 1 0", bus.O_RD_VALID, bus.O_RD_DATA);
    end
    drain_tile(100, 1'b1);
    for (int k = 0; k < 64; k++) begin
      checks++;
      if (got[k] !== 24'(k)) begin
        errors++;
        $display("FAIL identity_k%0d: got %0d, required %0d", k, got[k], k);
      end
    end
    checks++;
    if (bus.O_BUSY !== 1'b0 || bus.O_RD_VALID !== 1'b0 || bus.O_COUNT !== 7'd0) begin
      errors++;
      $display("FAIL identity_end: busy=%b valid=%b count=%0d, required 0 0 0",
               bus.O_BUSY, bus.O_RD_VALID, bus.O_COUNT);
    end
  endtask

  task automatic test_rot90();
    int          idx  [5];
    int          vals [5];
    logic [63:0] seen;
    idx  = '{0, 1, 7, 8, 63};
    vals = '{56, 48, 0, 57, 7};
    start_frame(1'b1, 2'd1);
    fill_tile(0, -1, 5);
    drain_tile(100, 1'b1);
    for (int n = 0; n < 5; n++) begin
      checks++;
      if (got[idx[n]] !== 24'(vals[n])) begin
        errors++;
        $display("FAIL rot90_k%0d: got %0d, required %0d", idx[n], got[idx[n]], vals[n]);
      end
    end
    seen = '0;
    for (int k = 0; k < 64; k++) begin
      got90[k] = got[k];
      if (got[k] < 24'd64) seen[got[k][5:0]] = 1'b1;
    end
    checks++;
    if (seen !== {64{1'b1}}) begin
      errors++;
      $display("FAIL rot90_perm: seen mask %h, required all ones", seen);
    end
  endtask

  task automatic test_rot180();
    start_frame(1'b1, 2'd2);
    fill_tile(0, -1, -1);
    drain_tile(100, 1'b1);
    checks++;
    if (got[0] !== 24'd63 || got[1] !== 24'd62 || got[63] !== 24'd0) begin
      errors++;
      $display("FAIL rot180: k0=%0d k1=%0d k63=%0d, required 63 62 0", got[0], got[1], got[63]);
    end
  endtask

  task automatic test_ccw();
    start_frame(1'b0, 2'd1);
    fill_tile(0, -1, -1);
    drain_tile(100, 1'b1);
    checks++;
    if (got[0] !== 24'd7 || got[1] !== 24'd15 || got[63] !== 24'd56) begin
      errors++;
      $display("FAIL ccw90: k0=%0d k1=%0d k63=%0d, required 7 15 56", got[0], got[1], got[63]);
    end
    start_frame(1'b0, 2'd3);
    fill_tile(0, -1, -1);
    drain_tile(100, 1'b1);
    checks++;
    if (got[0] !== 24'd56 || got[8] !== 24'd57 || got[63] !== 24'd7) begin
      errors++;
      $display("FAIL ccw270: k0=%0d k8=%0d k63=%0d, required 56 57 7", got[0], got[8], got[63]);
    end
  endtask

  task automatic test_backpressure();
    int bad;
    start_frame(1'b1, 2'd1);
    fill_tile(0, -1, -1);
    drain_tile(50, 1'b1);
    bad = 0;
    for (int k = 0; k < 64; k++) begin
      if (got[k] !== got90[k]) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL backpressure_seq: %0d pixels differ from the unstalled order, required 0", bad);
    end
  endtask

  task automatic test_back_to_back();
    start_frame(1'b1, 2'd0);
    fill_tile(0, -1, -1);
    drain_tile(100, 1'b0);
    checks++;
    if (bus.O_BUSY !== 1'b1 || bus.O_WR_READY !== 1'b1 || bus.O_COUNT !== 7'd0
        || bus.O_RD_VALID !== 1'b0) begin
      errors++;
      $display("FAIL refill: busy=%b wr_ready=%b count=%0d valid=%b, required 1 1 0 0",
               bus.O_BUSY, bus.O_WR_READY, bus.O_COUNT, bus.O_RD_VALID);
    end
    fill_tile(100, 10, -1);
    drain_tile(100, 1'b0);
    checks++;
    if (got[0] !== 24'd100 || got[9] !== 24'd109 || got[63] !== 24'd163) begin
      errors++;
      $display("FAIL tile2_data: k0=%0d k9=%0d k63=%0d, required 100 109 163",
               got[0], got[9], got[63]);
    end
    checks++;
    if (bus.O_BUSY !== 1'b0) begin
      errors++;
      $display("FAIL tile2_idle: busy=%b, required 0", bus.O_BUSY);
    end
  endtask

  task automatic test_abort();
    start_frame(1'b1, 2'd0);
    for (int k = 0; k < 30; k++) begin
      bus.I_WR_VALID = 1'b1;
      bus.I_WR_DATA  = 24'(k);
      step();
    end
    checks++;
    if (bus.O_COUNT !== 7'd30) begin
      errors++;
      $display("FAIL abort_precount: count=%0d, required 30", bus.O_COUNT);
    end
    bus.I_WR_DATA = 24'd30;
    bus.I_ABORT   = 1'b1;
    step();
    bus.I_ABORT    = 1'b0;
    bus.I_WR_VALID = 1'b0;
    checks++;
    if (bus.O_BUSY !== 1'b0 || bus.O_COUNT !== 7'd0 || bus.O_WR_READY !== 1'b0) begin
      errors++;
      $display("FAIL abort: busy=%b count=%0d wr_ready=%b, required 0 0 0",
               bus.O_BUSY, bus.O_COUNT, bus.O_WR_READY);
    end
    start_frame(1'b1, 2'd2);
    fill_tile(0, -1, -1);
    drain_tile(100, 1'b1);
    checks++;
    if (got[0] !== 24'd63 || got[63] !== 24'd0 || bus.O_BUSY !== 1'b0) begin
      errors++;
      $display("FAIL after_abort: k0=%0d k63=%0d busy=%b, required 63 0 0",
               got[0], got[63], bus.O_BUSY);
    end
  endtask

  task automatic test_async_reset();
    start_frame(1'b1, 2'd0);
    fill_tile(0, -1, -1);
    bus.I_RD_READY = 1'b1;
    repeat (10) step();
    checks++;
    if (bus.O_RD_VALID !== 1'b1 || bus.O_RD_DATA !== 24'd9) begin
      errors++;
      $display("FAIL mid_drain: valid=%b data=%0d, required 1 9", bus.O_RD_VALID, bus.O_RD_DATA);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.O_RD_VALID !== 1'b0 || bus.O_RD_DATA !== 24'd0 || bus.O_BUSY !== 1'b0
        || bus.O_COUNT !== 7'd0) begin
      errors++;
      $display("FAIL async_reset: valid=%b data=%0d busy=%b count=%0d, required 0 0 0 0",
               bus.O_RD_VALID, bus.O_RD_DATA, bus.O_BUSY, bus.O_COUNT);
    end
    bus.I_RD_READY = 1'b0;
    #1;
    rst_n = 1'b1;
    step();
    checks++;
    if (bus.O_BUSY !== 1'b0 || bus.O_WR_READY !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: busy=%b wr_ready=%b, required 0 0", bus.O_BUSY, bus.O_WR_READY);
    end
  endtask

  // Scenario sequence followed by the summary line.
  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_identity();
    test_rot90();
    test_rot180();
    test_ccw();
    test_backpressure();
    test_back_to_back();
    test_abort();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/core_tile_buf.md
Name: core_tile_buf

Overview:
- Pixel tile buffer between the DMA read-data path and the DMA write-data path of the rotate engine.
- Captures one 8x8 RGB888 tile (64 pixels, 24 bits each) arriving in row-major order while the address generator is in its READ phase.
- Replays the tile in rotated order during the WRITE phase, so the write addresses from the address generator line up with the rotated pixel stream.
- Processes tiles back-to-back until the frame's last tile is drained.

Parameters:
- PIX_W, 24, pixel width in bits (RGB888).
- TILE_DIM, 8, tile edge in pixels; the tile holds TILE_DIM*TILE_DIM = 64 entries.

Ports:
- I_HCLK  in  1  clock.
- I_HRESET_N  in  1  reset; asynchronous, active-low.
- I_START  in  1  one-cycle pulse that starts a frame; sampled only in IDLE.
- I_DIRECTION  in  1  1 = clockwise, 0 = counter-clockwise; latched on I_START.
- I_DEGREES  in  2  0=0, 1=90, 2=180, 3=270 degrees; latched on I_START.
- I_LAST_TILE  in  1  marks the current tile as the frame's last; may assert any cycle during FILL or DRAIN.
- I_ABORT  in  1  synchronous abort.
- I_WR_VALID  in  1  incoming pixel valid.
- I_WR_DATA  in  PIX_W  incoming pixel.
- O_WR_READY  out  1  buffer accepts a pixel.
- O_RD_VALID  out  1  rotated pixel valid.
- O_RD_DATA  out  PIX_W  rotated pixel.
- I_RD_READY  in  1  downstream accepts the pixel.
- O_COUNT  out  7  fill level, 0..64.
- O_BUSY  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (asynchronous, active-low): state=IDLE, wr_idx=0, rd_idx=0, O_RD_VALID=0, O_RD_DATA=0, O_COUNT=0, O_BUSY=0, O_WR_READY=0, latched config=0, last_flag=0. Storage array contents are not reset.
- States:
  - IDLE: I_START -> FILL at the next edge, latching the config and clearing last_flag.
  - FILL: O_WR_READY=1. Each edge with I_WR_VALID stores the pixel at wr_idx and increments wr_idx.
  - FILL -> DRAIN: at the edge that accepts the 64th pixel (wr_idx=63). O_WR_READY=0 from then on.
  - DRAIN: rd_idx runs 0..63. Output register loads on (!O_RD_VALID || I_RD_READY) while pixels remain. O_RD_DATA and O_RD_VALID are held stable while I_RD_READY=0.
  - DRAIN exit: at the edge where pixel 63 is accepted, O_RD_VALID drops. Next state is IDLE if last_flag (or I_LAST_TILE that cycle), else FILL. wr_idx and rd_idx clear.
- Latency:
  - First O_RD_VALID is 2 edges after the 64th write is accepted.
  - Throughput is 1 pixel/cycle in each phase; fill and drain never overlap.
- Rotation: effective degrees eff = I_DIRECTION ? I_DEGREES : (4 - I_DEGREES) mod 4. For output index k, i=k[5:3] and j=k[2:0]. Source index (row*8+col) is:
  - eff 0: (i, j).
  - eff 1 (90 CW): (7-j, i).
  - eff 2 (180): (7-i, 7-j).
  - eff 3 (270 CW): (j, 7-i).
  - All arithmetic is 3-bit unsigned, no carries.
- O_COUNT:
  - Increments on each write accept, reaching 64 at DRAIN entry.
  - Decrements on each read accept, reaching 0 at DRAIN exit.
- I_ABORT, any state: next edge goes to IDLE, clears indices, O_COUNT, O_RD_VALID and last_flag. I_ABORT has priority over every other event.
- Ignored inputs:
  - I_START outside IDLE.
  - I_WR_VALID outside FILL.
  - I_RD_READY when O_RD_VALID=0.
- Config changes after latch have no effect until the next I_START.
- Asynchronous reset mid-tile returns to IDLE immediately with all outputs at reset values.

Decomposition:
- Shared package core_pkg:
  - State encodings: IDLE=2'h0, FILL=2'h1, DRAIN=2'h2.
  - Degree constants: DEG_0..DEG_270 = 2'h0..2'h3.
  - TILE_PIX=64.
  - Function rot_index(eff, k) returning a 6-bit source index.
- Sub-module core_tile_ram:
  - 64 x PIX_W flop array.
  - One synchronous write port and one combinational read port.
  - No reset on the data.

Test Plan:
- Frame start, dir=1, deg=0, pixel value = its index: write 0..63 -> first O_RD_VALID 2 cycles after the last write; outputs 0,1,...,63; O_COUNT peaks at 64; O_BUSY drops after pixel 63 with I_LAST_TILE=1.
- dir=1, deg=1 (90 CW), same data -> outputs k0=56, k1=48, k7=0, k8=57, k63=7.
- dir=1, deg=2 -> k0=63, k63=0. dir=0, deg=1 (eff 270 CW) -> k0=7, k1=15, k63=56.
- Random I_RD_READY backpressure (about 50%) during DRAIN -> O_RD_DATA stable while stalled; the sequence equals the no-stall sequence; no pixel lost or duplicated.
- Two tiles with I_LAST_TILE only on the second -> FILL is re-entered after tile 1 with O_WR_READY high the cycle after the last read; IDLE after tile 2.
- Abort and reset:
  - I_ABORT at write 30 -> IDLE next cycle, O_COUNT=0; a new I_START then works normally.
  - Async I_HRESET_N low mid-DRAIN -> O_RD_VALID=0 without waiting for a clock edge.
